regbank_pc: RTL and testbench
=============================

Name: regbank_pc

Overview:
- Datapath register bank that sits directly downstream of the control unit.
- Consumes the control unit's RST, A_SEL, B_SEL, C_SEL, PCI and BRANCH strobes, drives the A and B buses into the external ALU, and commits the ALU's C-bus result.
- Owns the program counter (PC), the address register (AR), the data register (DR) and the general-purpose registers.
- Produces z_flag back to the control unit.

Parameters:
- DATA_W, 16, width of A/B/C buses and all data registers.
- PC_W, 8, width of the program counter.
- NUM_GPR, 8, number of general-purpose registers (1..11).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- rst_sel  in  4  register clear select (control unit RST)
- a_sel  in  4  A-bus source select
- b_sel  in  4  B-bus source select
- c_sel  in  4  C-bus destination select
- pci  in  1  PC increment strobe
- branch  in  1  branch strobe, qualifies a C-bus write to PC
- dm_load  in  1  load dm_rdata into DR this cycle
- dm_rdata  in  DATA_W  data-memory read data
- mux2_in  in  DATA_W  immediate/mux2 value, B-bus source
- c_bus  in  DATA_W  ALU result
- a_bus  out  DATA_W  A operand
- b_bus  out  DATA_W  B operand
- pc  out  PC_W  program counter, to instruction memory
- ar  out  DATA_W  address register, to data memory
- dr  out  DATA_W  data register, to data memory write data
- z_flag  out  1  result-nonzero flag

Behaviour:
- Select code map, shared by all four selects:
  - 0 = none
  - 1 = AR
  - 2 = DR
  - 3..2+NUM_GPR = GPR0..GPR(NUM_GPR-1)
  - 14 = MUX (b_sel only) / clear-all (rst_sel only)
  - 15 = PC
  - Codes 3+NUM_GPR..13 are unmapped.
- Reset (rst=1 at posedge): all registers, PC and z_flag go to 0. The outputs pc, ar, dr and z_flag therefore read 0 the cycle after. rst overrides every other input.
- a_bus and b_bus are combinational from the selects and current register contents (zero latency):
  - a_sel 15 returns PC zero-extended.
  - b_sel 14 returns mux2_in.
  - b_sel 15 returns PC zero-extended.
  - a_sel 14, code 0 and unmapped codes return 0.
- C-bus write, committed at the posedge when c_sel is in 1..2+NUM_GPR: destination <= c_bus. Code 0, 14 and unmapped codes are ignored.
- PC update, per posedge, priority high to low:
  - rst
  - rst_sel 15 or 14 -> 0
  - branch=1 and c_sel=15 -> c_bus[PC_W-1:0]
  - pci=1 -> pc+1, wrapping 2^PC_W-1 -> 0
  - otherwise hold.
  - c_sel=15 without branch does not write PC.
- Register clear:
  - rst_sel 1..2+NUM_GPR clears that register.
  - rst_sel 14 clears AR, DR, all GPRs and PC.
  - Unmapped codes do nothing.
- Per-register priority: rst > clear (rst_sel) > dm_load (DR only) > C-bus write.
  - Clear and C-bus write to the same register in one cycle -> register 0.
  - dm_load and C-bus write to DR in one cycle -> DR = dm_rdata.
- z_flag:
  - Updated only when a C-bus write to a register in 1..2+NUM_GPR commits and is not overridden by a clear or dm_load: z_flag <= (c_bus != 0).
  - Held on PC writes, clears, dm_load and idle cycles.
  - This polarity matches the control unit's JPNZ, which branches on z_flag=1.
- Reading and writing the same register in one cycle: a_bus/b_bus show the old value; the new value is visible the next cycle (no bypass).
- All other widths are truncation-free; c_bus is exactly DATA_W.

Decomposition:
- Shared package/include holds:
  - select code constants (sel_none=0, sel_ar=1, sel_dr=2, sel_gpr0=3, sel_mux=14, sel_all=14, sel_pc=15)
  - default DATA_W and PC_W
  - reused by the control unit's signal definitions.
- One natural sub-module: pc_counter (PC register with clear/load/increment priority).
- GPR array, bus read muxes and z_flag stay in the top.

Test Plan:
- rst=1 for 1 cycle after arbitrary writes -> pc=0, ar=0, dr=0, z_flag=0; a_sel=3 gives a_bus=0.
- c_sel=3, c_bus=16'h00A5; next cycle a_sel=3, b_sel=14, mux2_in=16'h1234 -> a_bus=16'h00A5, b_bus=16'h1234, z_flag=1. Then c_sel=3, c_bus=0 -> z_flag=0.
- pc=8'hFF, pci=1 -> pc=8'h00. Then pci=1, branch=1, c_sel=15, c_bus=16'h0042 in the same cycle -> pc=8'h42. Then c_sel=15, c_bus=7, branch=0, pci=0 -> pc stays 8'h42.
- DR=5, dm_load=1, dm_rdata=16'hBEEF, c_sel=2, c_bus=16'h0001 in the same cycle -> dr=16'hBEEF, z_flag unchanged.
- GPR1 (code 4)=9, rst_sel=4 and c_sel=4, c_bus=16'h0003 in the same cycle -> GPR1=0. Then rst_sel=14 -> AR, DR, all GPRs and pc = 0.
- c_sel=12 (unmapped, NUM_GPR=8), c_bus=16'hFFFF -> no register changes, z_flag held; a_sel=12 gives a_bus=0.

Source files
------------

// File: rtl/regbank_pc_pkg.sv
// Shared definitions for the datapath register bank: select-code map and
// default widths, also used by the control unit's signal definitions.
package regbank_pc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PC_W_DEF   = 8;

  // Select codes shared by a_sel, b_sel, c_sel and rst_sel.
  localparam logic [3:0] sel_none = 4'd0;
  localparam logic [3:0] sel_ar   = 4'd1;
  localparam logic [3:0] sel_dr   = 4'd2;
  localparam logic [3:0] sel_gpr0 = 4'd3;
  localparam logic [3:0] sel_mux  = 4'd14;  // b_sel only
  localparam logic [3:0] sel_all  = 4'd14;  // rst_sel only
  localparam logic [3:0] sel_pc   = 4'd15;

  // Select code of general-purpose register idx.
  function automatic logic [3:0] gpr_code(input int idx);
    return 4'(int'(sel_gpr0) + idx);
  endfunction

endpackage

// File: rtl/regbank_pc_pc_counter.sv
// Program counter: clear beats branch load, load beats increment, else hold.
module regbank_pc_pc_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next-PC selection with clear > load > increment > hold priority.
  always_comb begin
    // NOTE: the hold value is assigned first so every path drives pc_d and no latch is inferred.
    pc_d = pc_q;
    if (clr) begin
      pc_d = '0;
    end else if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);  // wraps naturally at 2^PC_W
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/regbank_pc.sv
// Datapath register bank: AR, DR, GPRs, PC, A/B read muxes, C-bus commit
// and the result-nonzero flag fed back to the control unit.
module regbank_pc
  import regbank_pc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int NUM_GPR = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rst_sel,
  input  logic [3:0]        a_sel,
  input  logic [3:0]        b_sel,
  input  logic [3:0]        c_sel,
  input  logic              pci,
  input  logic              branch,
  input  logic              dm_load,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic [DATA_W-1:0] mux2_in,
  input  logic [DATA_W-1:0] c_bus,
  output logic [DATA_W-1:0] a_bus,
  output logic [DATA_W-1:0] b_bus,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] ar,
  output logic [DATA_W-1:0] dr,
  output logic              z_flag
);

  logic [DATA_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0] gpr_q [NUM_GPR];
  logic [DATA_W-1:0] gpr_d [NUM_GPR];
  logic              z_q, z_d;
  logic [PC_W-1:0]   pc_val;

  logic clr_all;
  assign clr_all = (rst_sel == sel_all);

  // Program counter: clear on rst_sel PC/all, load only on a qualified branch.
  regbank_pc_pc_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_all || (rst_sel == sel_pc)),
    .load     (branch && (c_sel == sel_pc)),
    .load_val (c_bus[PC_W-1:0]),
    .inc      (pci),
    .pc       (pc_val)
  );

  // Per-register next state: clear > dm_load (DR) > C-bus write; z tracks surviving writes.
  always_comb begin
    ar_d  = ar_q;
    dr_d  = dr_q;
    gpr_d = gpr_q;
    z_d   = z_q;

    if (clr_all || (rst_sel == sel_ar)) begin
      ar_d = '0;
    end else if (c_sel == sel_ar) begin
      ar_d = c_bus;
      z_d  = (c_bus != '0);
    end

    if (clr_all || (rst_sel == sel_dr)) begin
      dr_d = '0;
    end else if (dm_load) begin
      dr_d = dm_rdata;
    end else if (c_sel == sel_dr) begin
      dr_d = c_bus;
      z_d  = (c_bus != '0);
    end

    for (int i = 0; i < NUM_GPR; i++) begin
      if (clr_all || (rst_sel == gpr_code(i))) begin
        gpr_d[i] = '0;
      end else if (c_sel == gpr_code(i)) begin
        gpr_d[i] = c_bus;
        z_d      = (c_bus != '0);
      end
    end
  end

  // Register state with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_q <= '0;
      dr_q <= '0;
      z_q  <= 1'b0;
      // NOTE: the GPR array is a handful of flops, not a RAM, so it takes the reset like any register.
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr_q[i] <= '0;
      end
    end else begin
      ar_q  <= ar_d;
      dr_q  <= dr_d;
      z_q   <= z_d;
      gpr_q <= gpr_d;
    end
  end

  // A-bus source mux; no bypass, so a same-cycle write shows next cycle.
  always_comb begin
    a_bus = '0;
    case (a_sel)
      sel_none: a_bus = '0;
      sel_ar:   a_bus = ar_q;
      sel_dr:   a_bus = dr_q;
      sel_pc:   a_bus = DATA_W'(pc_val);
      default: begin
        for (int i = 0; i < NUM_GPR; i++) begin
          if (a_sel == gpr_code(i)) a_bus = gpr_q[i];
        end
      end
    endcase
  end

  // B-bus source mux; additionally offers the immediate/mux2 value.
  always_comb begin
    b_bus = '0;
    case (b_sel)
      sel_none: b_bus = '0;
      sel_ar:   b_bus = ar_q;
      sel_dr:   b_bus = dr_q;
      sel_mux:  b_bus = mux2_in;
      sel_pc:   b_bus = DATA_W'(pc_val);
      default: begin
        for (int i = 0; i < NUM_GPR; i++) begin
          if (b_sel == gpr_code(i)) b_bus = gpr_q[i];
        end
      end
    endcase
  end

  assign pc     = pc_val;
  assign ar     = ar_q;
  assign dr     = dr_q;
  assign z_flag = z_q;

endmodule

// File: tb/tb_regbank_pc.sv
// Directed bench for regbank_pc: stimulus pushes expectations into a
// scoreboard queue, a monitor compares them at the falling edge.
module tb_regbank_pc;

  localparam int DATA_W = 16;
  localparam int PC_W   = 8;

  typedef enum int {OBS_PC, OBS_AR, OBS_DR, OBS_Z, OBS_A, OBS_B} obs_e;

  typedef struct {
    int    cyc;
    obs_e  kind;
    logic [DATA_W-1:0] val;
    string name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        rst_sel, a_sel, b_sel, c_sel;
  logic              pci, branch, dm_load;
  logic [DATA_W-1:0] dm_rdata, mux2_in, c_bus;
  logic [DATA_W-1:0] a_bus, b_bus, ar, dr;
  logic [PC_W-1:0]   pc;
  logic              z_flag;

  exp_t sb_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  regbank_pc #(.DATA_W(DATA_W), .PC_W(PC_W), .NUM_GPR(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rst_sel  (rst_sel),
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .c_sel    (c_sel),
    .pci      (pci),
    .branch   (branch),
    .dm_load  (dm_load),
    .dm_rdata (dm_rdata),
    .mux2_in  (mux2_in),
    .c_bus    (c_bus),
    .a_bus    (a_bus),
    .b_bus    (b_bus),
    .pc       (pc),
    .ar       (ar),
    .dr       (dr),
    .z_flag   (z_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] observe(input obs_e k);
    case (k)
      OBS_PC:  return DATA_W'(pc);
      OBS_AR:  return ar;
      OBS_DR:  return dr;
      OBS_Z:   return DATA_W'(z_flag);
      OBS_A:   return a_bus;
      default: return b_bus;
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [DATA_W-1:0] act;
    act = observe(e.kind);
    n_tests++;
    if (act !== e.val) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.val, cyc);
    end
  endtask

  // Monitor: drain every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      check(sb_q.pop_front());
    end
  end

  task automatic expect_now(input obs_e k, input logic [DATA_W-1:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_sel = 4'd0; c_sel = 4'd0; pci = 1'b0; branch = 1'b0; dm_load = 1'b0;
    c_bus = '0; dm_rdata = '0;
  endtask

  task automatic cwrite(input logic [3:0] sel, input logic [DATA_W-1:0] v);
    idle();
    c_sel = sel;
    c_bus = v;
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    a_sel = 4'd0; b_sel = 4'd0; mux2_in = '0;
    idle();
    step();
    rst = 1'b0;

    // Arbitrary writes, then reset clears them.
    cwrite(4'd1, 16'h1111);
    c_sel = 4'd3; c_bus = 16'h2222; pci = 1'b1;
    step();
    idle();
    expect_now(OBS_AR, 16'h1111, "pre_rst_ar");
    expect_now(OBS_PC, 16'h0001, "pre_rst_pc");
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_sel = 4'd3;
    expect_now(OBS_PC, 16'h0000, "rst_pc");
    expect_now(OBS_AR, 16'h0000, "rst_ar");
    expect_now(OBS_DR, 16'h0000, "rst_dr");
    expect_now(OBS_Z,  16'h0000, "rst_z");
    expect_now(OBS_A,  16'h0000, "rst_gpr0");

    // GPR0 write and A/B read, then zero write drops z_flag.
    cwrite(4'd3, 16'h00A5);
    a_sel = 4'd3; b_sel = 4'd14; mux2_in = 16'h1234;
    expect_now(OBS_A, 16'h00A5, "gpr0_read");
    expect_now(OBS_B, 16'h1234, "mux2_read");
    expect_now(OBS_Z, 16'h0001, "z_set");
    c_sel = 4'd3; c_bus = 16'h0000;
    #2;
    expect_now(OBS_A, 16'h00A5, "no_bypass");
    step();
    idle();
    expect_now(OBS_Z, 16'h0000, "z_clear");
    expect_now(OBS_A, 16'h0000, "gpr0_zero");

    // PC: branch load to FF, wrap, branch beats pci, c_sel=15 without branch holds.
    branch = 1'b1; c_sel = 4'd15; c_bus = 16'h00FF;
    step();
    idle();
    b_sel = 4'd15;
    expect_now(OBS_PC, 16'h00FF, "pc_branch_ff");
    expect_now(OBS_B,  16'h00FF, "b_pc_zext");
    expect_now(OBS_Z,  16'h0000, "z_hold_pcwr");
    pci = 1'b1;
    step();
    idle();
    expect_now(OBS_PC, 16'h0000, "pc_wrap");
    pci = 1'b1; branch = 1'b1; c_sel = 4'd15; c_bus = 16'h0042;
    step();
    idle();
    expect_now(OBS_PC, 16'h0042, "pc_branch_prio");
    c_sel = 4'd15; c_bus = 16'h0007;
    step();
    idle();
    a_sel = 4'd15;
    expect_now(OBS_PC, 16'h0042, "pc_no_branch");
    expect_now(OBS_A,  16'h0042, "a_pc_zext");

    // dm_load beats C-bus write to DR and leaves z_flag alone.
    cwrite(4'd2, 16'h0005);
    expect_now(OBS_DR, 16'h0005, "dr_write");
    cwrite(4'd1, 16'h0000);
    expect_now(OBS_Z, 16'h0000, "z_zero_ar");
    dm_load = 1'b1; dm_rdata = 16'hBEEF; c_sel = 4'd2; c_bus = 16'h0001;
    step();
    idle();
    expect_now(OBS_DR, 16'hBEEF, "dm_load_prio");
    expect_now(OBS_Z,  16'h0000, "z_hold_dmload");

    // Clear beats C-bus write on GPR1; then clear-all.
    cwrite(4'd4, 16'h0009);
    a_sel = 4'd4;
    expect_now(OBS_A, 16'h0009, "gpr1_write");
    cwrite(4'd1, 16'h0000);
    rst_sel = 4'd4; c_sel = 4'd4; c_bus = 16'h0003;
    step();
    idle();
    expect_now(OBS_A, 16'h0000, "gpr1_clear_prio");
    expect_now(OBS_Z, 16'h0000, "z_hold_clear");
    cwrite(4'd1, 16'h0077);
    cwrite(4'd10, 16'h0088);
    a_sel = 4'd10;
    expect_now(OBS_A, 16'h0088, "gpr7_write");
    rst_sel = 4'd14; pci = 1'b1; c_sel = 4'd10; c_bus = 16'h0055;
    step();
    idle();
    b_sel = 4'd1;
    expect_now(OBS_A,  16'h0000, "clrall_gpr7");
    expect_now(OBS_B,  16'h0000, "clrall_ar");
    expect_now(OBS_DR, 16'h0000, "clrall_dr");
    expect_now(OBS_PC, 16'h0000, "clrall_pc");

    // Unmapped destination: nothing changes, z held, unmapped read is 0.
    cwrite(4'd3, 16'h0000);
    cwrite(4'd12, 16'hFFFF);
    a_sel = 4'd12; b_sel = 4'd12;
    expect_now(OBS_Z,  16'h0000, "z_hold_unmapped");
    expect_now(OBS_AR, 16'h0000, "unmapped_ar");
    expect_now(OBS_DR, 16'h0000, "unmapped_dr");
    expect_now(OBS_PC, 16'h0000, "unmapped_pc");
    expect_now(OBS_A,  16'h0000, "a_unmapped");
    expect_now(OBS_B,  16'h0000, "b_unmapped");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) step();
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
